// File: rtl/timer_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : NUM_CH independent up-counters behind one 68000-style 16-bit
//            slave port. Each channel has a power-of-two prescaler, a compare
//            register, periodic/one-shot mode and a sticky match flag with
//            an interrupt enable.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            data_write      - write data (uds lane [15:8], lds lane [7:0])
//            data_read       - registered read data, 0 while ack is low
//            addr            - [7:4] channel, [3:1] register word, [0] unused
//            uds, lds, rw    - data strobes (active high), 1 = read
//            ack             - transfer acknowledge
//            overflow        - per-channel interrupt = FLAG & IRQ_EN
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       data_write,
    output logic [15:0]       data_read,
    input  logic [7:0]        addr,
    input  logic              uds,
    input  logic              lds,
    input  logic              rw,
    output logic              ack,
    output logic [NUM_CH-1:0] overflow
);

    logic        w_stb;
    logic        w_wr;
    logic [2:0]  w_off;
    logic [15:0] w_rdata;
    logic [15:0] w_ch_rd [NUM_CH];
    logic        w_unused;

    assign w_stb    = uds | lds;
    // A write is committed only on the edge where ack rises.
    assign w_wr     = w_stb & ~ack & ~rw;
    assign w_off    = addr[3:1];
    assign w_unused = addr[0];

    // Byte-lane merge of a 16-bit half.
    function automatic logic [15:0] f_merge(input logic [15:0] old_val,
                                            input logic [15:0] wd,
                                            input logic        u,
                                            input logic        l);
        f_merge = {(u ? wd[15:8] : old_val[15:8]), (l ? wd[7:0] : old_val[7:0])};
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_cmp;
        logic             r_en;
        logic             r_oneshot;
        logic             r_irq_en;
        logic             r_flag;
        logic [PRE_W-1:0] r_presc;
        logic [31:0]      r_pre;

        logic [31:0]      w_cnt32;
        logic [31:0]      w_cmp32;
        logic [31:0]      w_cnt_new;
        logic [31:0]      w_cmp_new;
        logic [31:0]      w_mask;
        logic [15:0]      w_ctrl;
        logic [15:0]      w_rd;
        logic             w_sel;
        logic             w_wr_cnt;
        logic             w_wr_cmp;
        logic             w_wr_ctrl;
        logic             w_wr_stat;
        logic             w_tick;
        logic             w_match;

        assign w_cnt32 = 32'(r_cnt);
        assign w_cmp32 = 32'(r_cmp);

        assign w_sel     = w_wr && (addr[7:4] == 4'(i));
        assign w_wr_cnt  = w_sel && (w_off == 3'd0 || w_off == 3'd1);
        assign w_wr_cmp  = w_sel && (w_off == 3'd2 || w_off == 3'd3);
        assign w_wr_ctrl = w_sel && (w_off == 3'd4);
        assign w_wr_stat = w_sel && (w_off == 3'd5);

        // The 32-bit registers are written as two independent halves.
        assign w_cnt_new = (w_off == 3'd0)
            ? {f_merge(w_cnt32[31:16], data_write, uds, lds), w_cnt32[15:0]}
            : {w_cnt32[31:16], f_merge(w_cnt32[15:0], data_write, uds, lds)};
        assign w_cmp_new = (w_off == 3'd2)
            ? {f_merge(w_cmp32[31:16], data_write, uds, lds), w_cmp32[15:0]}
            : {w_cmp32[31:16], f_merge(w_cmp32[15:0], data_write, uds, lds)};

        // Low p bits of the prescaler all ones -> tick; p saturates at 31.
        always_comb begin
            if (int'(r_presc) >= 31) begin
                w_mask = 32'h7FFF_FFFF;
            end else begin
                w_mask = (32'h1 << r_presc) - 32'h1;
            end
        end

        assign w_tick = r_en && ((r_pre & w_mask) == w_mask);
        // A bus write to CNT or CTRL swallows a coincident tick entirely.
        assign w_match = w_tick && !w_wr_cnt && !w_wr_ctrl && (r_cnt == r_cmp);

        always_comb begin
            w_ctrl          = 16'h0000;
            w_ctrl[0]       = r_en;
            w_ctrl[PRE_W:1] = r_presc;
            w_ctrl[6]       = r_oneshot;
            w_ctrl[7]       = r_irq_en;
        end

        always_comb begin
            case (w_off)
                3'd0:    w_rd = w_cnt32[31:16];
                3'd1:    w_rd = w_cnt32[15:0];
                3'd2:    w_rd = w_cmp32[31:16];
                3'd3:    w_rd = w_cmp32[15:0];
                3'd4:    w_rd = w_ctrl;
                3'd5:    w_rd = {15'h0000, r_flag};
                default: w_rd = 16'h0000;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt     <= '0;
                r_cmp     <= '0;
                r_en      <= 1'b0;
                r_oneshot <= 1'b0;
                r_irq_en  <= 1'b0;
                r_flag    <= 1'b0;
                r_presc   <= '0;
                r_pre     <= 32'd0;
            end else begin
                r_pre <= r_en ? (r_pre + 32'd1) : 32'd0;

                if (w_wr_cmp) begin
                    r_cmp <= w_cmp_new[CNT_W-1:0];
                end

                if (w_wr_cnt) begin
                    r_cnt <= w_cnt_new[CNT_W-1:0];
                end else if (w_match) begin
                    if (!r_oneshot) begin
                        r_cnt <= '0;
                    end
                end else if (w_tick && !w_wr_ctrl) begin
                    // Natural wrap at 2^CNT_W-1 does not touch the flag.
                    r_cnt <= r_cnt + CNT_W'(1);
                end

                // All CTRL fields live in the low byte.
                if (w_wr_ctrl) begin
                    if (lds) begin
                        r_en      <= data_write[0];
                        r_presc   <= data_write[PRE_W:1];
                        r_oneshot <= data_write[6];
                        r_irq_en  <= data_write[7];
                    end
                end else if (w_match && r_oneshot) begin
                    r_en <= 1'b0;
                end

                // A new match beats a coincident write-1-to-clear.
                if (w_match) begin
                    r_flag <= 1'b1;
                end else if (w_wr_stat && lds && data_write[0]) begin
                    r_flag <= 1'b0;
                end
            end
        end

        assign w_ch_rd[i]  = w_rd;
        assign overflow[i] = r_flag & r_irq_en;
    end

    // Channels at or above NUM_CH fall through and read as zero.
    always_comb begin
        w_rdata = 16'h0000;
        for (int k = 0; k < NUM_CH; k++) begin
            if (addr[7:4] == 4'(k)) begin
                w_rdata = w_ch_rd[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack       <= 1'b0;
            data_read <= 16'h0000;
        end else if (w_stb) begin
            ack <= 1'b1;
            if (!ack) begin
                data_read <= rw ? w_rdata : 16'h0000;
            end
        end else begin
            ack       <= 1'b0;
            data_read <= 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi
// Purpose  : Self-checking bench for timer_multi (NUM_CH=2, CNT_W=32).
//            Directed register/timing steps followed by random bus traffic
//            compared against a behavioural model of the channels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi;

    logic        clk;
    logic        reset;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [7:0]  addr;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        ack;
    logic [1:0]  overflow;

    int n_checks = 0;
    int n_err    = 0;

    timer_multi #(.NUM_CH(2), .CNT_W(32), .PRE_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_write (data_write),
        .data_read  (data_read),
        .addr       (addr),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .ack        (ack),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_cnt [2];
    logic [31:0] m_cmp [2];
    bit          m_en  [2];
    bit          m_os  [2];
    bit          m_irq [2];
    bit          m_flag[2];
    int          m_p   [2];
    int          m_age [2];   // clocks spent enabled
    bit          m_ack;
    logic [15:0] m_rd;

    function automatic logic [15:0] lane(input logic [15:0] o, input logic [15:0] d,
                                         input bit u, input bit l);
        lane = {(u ? d[15:8] : o[15:8]), (l ? d[7:0] : o[7:0])};
    endfunction

    function automatic logic [15:0] m_read(input int ch, input int off);
        if (ch >= 2) return 16'h0000;
        case (off)
            0: return m_cnt[ch][31:16];
            1: return m_cnt[ch][15:0];
            2: return m_cmp[ch][31:16];
            3: return m_cmp[ch][15:0];
            4: return {8'h00, m_irq[ch], m_os[ch], 5'(m_p[ch]), m_en[ch]};
            5: return {15'h0000, m_flag[ch]};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [1:0] m_ovf();
        return {m_flag[1] & m_irq[1], m_flag[0] & m_irq[0]};
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sees.
    task automatic model_step();
        int ch, off;
        bit stb, first, wr, sel, wcnt, wctrl, tick, match, inc, old_en;
        longint div;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_cnt[c] = 0; m_cmp[c] = 0; m_en[c] = 0; m_os[c] = 0;
                m_irq[c] = 0; m_flag[c] = 0; m_p[c] = 0; m_age[c] = 0;
            end
            m_ack = 0;
            m_rd  = 16'h0000;
        end else begin
            ch    = int'(addr[7:4]);
            off   = int'(addr[3:1]);
            stb   = uds | lds;
            first = stb && !m_ack;
            wr    = first && !rw;
            if (first) m_rd = rw ? m_read(ch, off) : 16'h0000;
            else if (!stb) m_rd = 16'h0000;
            for (int c = 0; c < 2; c++) begin
                sel    = wr && (ch == c);
                wcnt   = sel && (off == 0 || off == 1);
                wctrl  = sel && (off == 4);
                div    = longint'(1) << m_p[c];
                tick   = m_en[c] && ((longint'(m_age[c]) % div) == div - 1);
                match  = tick && !wcnt && !wctrl && (m_cnt[c] == m_cmp[c]);
                inc    = tick && !wcnt && !wctrl && !match;
                old_en = m_en[c];
                if (sel) begin
                    case (off)
                        0: m_cnt[c][31:16] = lane(m_cnt[c][31:16], data_write, uds, lds);
                        1: m_cnt[c][15:0]  = lane(m_cnt[c][15:0],  data_write, uds, lds);
                        2: m_cmp[c][31:16] = lane(m_cmp[c][31:16], data_write, uds, lds);
                        3: m_cmp[c][15:0]  = lane(m_cmp[c][15:0],  data_write, uds, lds);
                        4: if (lds) begin
                               m_en[c]  = data_write[0];
                               m_p[c]   = int'(data_write[5:1]);
                               m_os[c]  = data_write[6];
                               m_irq[c] = data_write[7];
                           end
                        5: if (lds && data_write[0]) m_flag[c] = 0;
                        default: ;
                    endcase
                end
                if (match) begin
                    m_flag[c] = 1;
                    if (m_os[c]) m_en[c] = 0;
                    else m_cnt[c] = 0;
                end else if (inc) begin
                    m_cnt[c] = m_cnt[c] + 32'd1;
                end
                m_age[c] = old_en ? m_age[c] + 1 : 0;
            end
            m_ack = stb;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every rising edge goes through here so the model never misses one.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    time t_edge;

    task automatic bus(input bit is_rd, input logic [7:0] a, input logic [15:0] d,
                       input bit u, input bit l, input int hold, output logic [15:0] rd);
        @(negedge clk);
        addr = a; rw = is_rd; data_write = d; uds = u; lds = l;
        step();
        t_edge = $time;
        check("ack_rise", ack, 1);
        check("rdata", data_read, m_rd);
        rd = data_read;
        for (int h = 0; h < hold; h++) begin
            step();
            check("ack_hold", ack, 1);
            check("rdata_hold", data_read, m_rd);
        end
        @(negedge clk);
        uds = 0; lds = 0;
        step();
        check("ack_fall", ack, 0);
        check("rdata_idle", data_read, 0);
        check("overflow", overflow, m_ovf());
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus(1'b0, a, d, 1'b1, 1'b1, 0, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus(1'b1, a, 16'h0000, 1'b1, 1'b1, 0, v);
        check(tag, v, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [15:0] v;
        reset = 1; uds = 0; lds = 0; rw = 1; addr = 0; data_write = 0;
        repeat (3) step();
        check("rst_ack", ack, 0);
        check("rst_rdata", data_read, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        reset = 0;

        // Every register of ch0 and ch1 reads zero after reset.
        for (int c = 0; c < 2; c++)
            for (int o = 0; o < 8; o++)
                rd_chk("rst_reg", 8'((c << 4) | (o << 1)), 16'h0000);

        // ch0 periodic: match 257 clocks after EN, counter restarts at 0.
        wr(8'h04, 16'h0000);
        wr(8'h06, 16'h0100);
        wr(8'h08, 16'h0081);
        n = 0;
        while (!overflow[0] && n < 400) begin
            step();
            n++;
        end
        check("match_seen", overflow[0], 1);
        check("match_latency", 32'(($time - t_edge) / 10), 257);
        rd_chk("cnt_after_match", 8'h02, 16'h0000);
        rd_chk("cnt_running", 8'h02, 16'h0002);
        wr(8'h0A, 16'h0001);
        check("ovf0_w1c", overflow[0], 0);
        wr(8'h08, 16'h0000);

        // ch1 one-shot with p=2.
        wr(8'h16, 16'h0003);
        wr(8'h18, 16'h0045);
        repeat (4) step();
        rd_chk("os_cnt_mid", 8'h12, 16'h0001);
        repeat (20) step();
        rd_chk("os_cnt_stop", 8'h12, 16'h0003);
        rd_chk("os_ctrl", 8'h18, 16'h0044);
        rd_chk("os_flag", 8'h1A, 16'h0001);
        check("os_ovf1", overflow[1], 0);

        // Byte lanes on ch0 CMP low half.
        wr(8'h06, 16'h0000);
        bus(1'b0, 8'h06, 16'hAABB, 1'b0, 1'b1, 0, v);
        rd_chk("lane_lds", 8'h06, 16'h00BB);
        bus(1'b0, 8'h06, 16'hAABB, 1'b1, 1'b0, 1, v);
        rd_chk("lane_uds", 8'h06, 16'hAABB);

        // Wrap from 0xFFFFFFFE without flag, then match at 0x10.
        wr(8'h0A, 16'h0001);
        wr(8'h00, 16'hFFFF);
        wr(8'h02, 16'hFFFE);
        wr(8'h04, 16'h0000);
        wr(8'h06, 16'h0010);
        wr(8'h08, 16'h0001);
        rd_chk("wrap_hi_pre", 8'h00, 16'hFFFF);
        rd_chk("wrap_hi_post", 8'h00, 16'h0000);
        rd_chk("wrap_noflag", 8'h0A, 16'h0000);
        repeat (30) step();
        rd_chk("wrap_match", 8'h0A, 16'h0001);

        // CNT write on a tick cycle: the tick is dropped.
        wr(8'h02, 16'h0005);
        rd_chk("tick_write", 8'h02, 16'h0006);

        // W1C on the exact match edge: set wins.
        wr(8'h08, 16'h0000);
        wr(8'h0A, 16'h0001);
        rd_chk("flag_cleared", 8'h0A, 16'h0000);
        wr(8'h00, 16'h0000);
        wr(8'h02, 16'h000C);
        wr(8'h08, 16'h0001);
        repeat (3) step();
        wr(8'h0A, 16'h0001);
        rd_chk("w1c_vs_set", 8'h0A, 16'h0001);

        // Channel index beyond NUM_CH.
        rd_chk("oor_read", 8'hF0, 16'h0000);
        wr(8'hF6, 16'hFFFF);
        rd_chk("oor_read2", 8'hF6, 16'h0000);

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            int c, off, lanes;
            logic [7:0]  a;
            logic [15:0] d;
            c     = $urandom_range(0, 2);
            off   = $urandom_range(0, 7);
            lanes = $urandom_range(1, 3);
            a = {((c == 2) ? 4'hF : 4'(c)), 3'(off), 1'($urandom_range(0, 1))};
            case (off)
                1, 3:    d = 16'($urandom_range(0, 40));
                0, 2:    d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
                4:       d = {8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
                default: d = 16'($urandom);
            endcase
            bus(1'($urandom_range(0, 1)), a, d, lanes[1], lanes[0],
                $urandom_range(0, 2), v);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
